// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker: locks onto a serial LFSR stream, then flywheels and counts bit errors.
// Optional LFSR_CHK_BER_EN adds a saturating compared-bit counter (bit_cnt) for BER measurement.
module lfsr_checker #(
   parameter int                     LFSR_LENGTH    = 4,
   parameter logic [LFSR_LENGTH-1:0] LFSR_PRIM_POLY = 4'b1101,
   parameter int                     LOCK_CNT       = 8,
   parameter int                     WINDOW         = 16,
   parameter int                     UNLOCK_ERR     = 3,
   parameter int                     ERR_CNT_W      = 16
) (
   input  logic                   lfsr_clk,
   input  logic                   resetn,
   input  logic                   lfsr_en,
   input  logic                   rx_bit,
   input  logic                   err_clr,
   output logic                   locked,
   output logic                   bit_err,
   output logic [ERR_CNT_W-1:0]   err_cnt,
`ifdef LFSR_CHK_BER_EN
   output logic [ERR_CNT_W+7:0]   bit_cnt,
`endif
   output logic [LFSR_LENGTH-1:0] lfsr_state_out
);

   localparam int N       = LFSR_LENGTH;
   localparam int FILL_W  = $clog2(N + 1);
   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int WIN_W   = $clog2(WINDOW);
   localparam int WERR_W  = $clog2(UNLOCK_ERR + 1);
   localparam logic [N-1:0] TAP_MASK = {LFSR_PRIM_POLY[N-1:1], 1'b0};

   typedef enum logic [1:0] {FILL, VERIFY, LOCKED} state_t;

   state_t                 state_q, state_d;
   logic [N-1:0]           r_q, r_d;
   logic [FILL_W-1:0]      fill_cnt_q, fill_cnt_d;
   logic [MATCH_W-1:0]     match_cnt_q, match_cnt_d;
   logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
   logic [WERR_W-1:0]      win_err_q, win_err_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic                   bit_err_q, bit_err_d;
   logic                   locked_q, locked_d;
   logic                   expBit, mismatch, errInc, compared;
   logic [WERR_W-1:0]      winErrNext;
`ifdef LFSR_CHK_BER_EN
   logic [ERR_CNT_W+7:0]   bit_cnt_q, bit_cnt_d;
`endif

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      fill_cnt_d  = fill_cnt_q;
      match_cnt_d = match_cnt_q;
      win_cnt_d   = win_cnt_q;
      win_err_d   = win_err_q;
      bit_err_d   = 1'b0;
      errInc      = 1'b0;
      compared    = 1'b0;
      expBit      = ^(r_q & TAP_MASK);
      mismatch    = rx_bit ^ expBit;
      winErrNext  = win_err_q + WERR_W'(mismatch);

      if (lfsr_en) begin
         case (state_q)
            FILL: begin
               r_d = {r_q[N-2:0], rx_bit};
               if (fill_cnt_q == FILL_W'(N - 1)) begin
                  state_d     = VERIFY;
                  fill_cnt_d  = '0;
                  match_cnt_d = '0;
               end else begin
                  fill_cnt_d = fill_cnt_q + 1'b1;
               end
            end
            VERIFY: begin
               // An all-zero history predicts zero forever, so it never counts as a match.
               r_d = {r_q[N-2:0], rx_bit};
               if (!mismatch && (r_q != '0)) begin
                  if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
                     state_d     = LOCKED;
                     match_cnt_d = '0;
                     win_cnt_d   = '0;
                     win_err_d   = '0;
                  end else begin
                     match_cnt_d = match_cnt_q + 1'b1;
                  end
               end else begin
                  match_cnt_d = '0;
               end
            end
            LOCKED: begin
               compared  = 1'b1;
               r_d       = {r_q[N-2:0], expBit};
               bit_err_d = mismatch;
               errInc    = mismatch;
               // Unlock beats the window wrap when both land on the same bit.
               if (mismatch && (winErrNext == WERR_W'(UNLOCK_ERR))) begin
                  state_d     = FILL;
                  r_d         = '0;
                  fill_cnt_d  = '0;
                  match_cnt_d = '0;
                  win_cnt_d   = '0;
                  win_err_d   = '0;
               end else if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else begin
                  win_cnt_d = win_cnt_q + 1'b1;
                  win_err_d = winErrNext;
               end
            end
            default: state_d = FILL;
         endcase
      end

      locked_d = (state_d == LOCKED);

      err_cnt_d = err_cnt_q;
      if (err_clr)
         err_cnt_d = '0;
      else if (errInc && (err_cnt_q != '1))
         err_cnt_d = err_cnt_q + 1'b1;

`ifdef LFSR_CHK_BER_EN
      bit_cnt_d = bit_cnt_q;
      if (err_clr)
         bit_cnt_d = '0;
      else if (compared && (bit_cnt_q != '1))
         bit_cnt_d = bit_cnt_q + 1'b1;
`endif
   end

   always_ff @(posedge lfsr_clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= FILL;
         r_q         <= '0;
         fill_cnt_q  <= '0;
         match_cnt_q <= '0;
         win_cnt_q   <= '0;
         win_err_q   <= '0;
         err_cnt_q   <= '0;
         bit_err_q   <= 1'b0;
         locked_q    <= 1'b0;
`ifdef LFSR_CHK_BER_EN
         bit_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         fill_cnt_q  <= fill_cnt_d;
         match_cnt_q <= match_cnt_d;
         win_cnt_q   <= win_cnt_d;
         win_err_q   <= win_err_d;
         err_cnt_q   <= err_cnt_d;
         bit_err_q   <= bit_err_d;
         locked_q    <= locked_d;
`ifdef LFSR_CHK_BER_EN
         bit_cnt_q   <= bit_cnt_d;
`endif
      end
   end

   assign locked         = locked_q;
   assign bit_err        = bit_err_q;
   assign err_cnt        = err_cnt_q;
   assign lfsr_state_out = r_q;
`ifdef LFSR_CHK_BER_EN
   assign bit_cnt        = bit_cnt_q;
`endif

endmodule
